exec_muldiv: RTL
================

Name: exec_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit beside the single-cycle ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and services MTHI/MTLO writes.
- Core iterates one bit per cycle; busy/done handshake lets the pipeline stall on MFHI/MFLO until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be >= 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request an operation; sampled only while busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  rs operand (multiplicand / dividend)
- src_b  in  WIDTH  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; HI/LO valid
- div_zero  out  1  last completed division had divisor 0; sticky until the next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0. Reset in any state aborts the operation with no HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op, operand signs and operand magnitudes (signed ops take the two's-complement abs; unsigned ops pass through).
  - Counter is loaded with WIDTH; busy=1; div_zero cleared; next state CALC.
- CALC:
  - Multiply: shift-add, 2*WIDTH-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle; remainder WIDTH+1 bits.
  - Counter decrements each cycle; when it reaches 0 the next state is FIX.
- FIX:
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Load hi/lo (multiply: hi=product[2W-1:W], lo=product[W-1:0]; divide: lo=quotient, hi=remainder).
  - Same edge: done=1, busy=0, state IDLE.
- Latency: with start sampled at edge 0, done is high after edge WIDTH+1 (edge 33 for WIDTH=32). busy is high from edge 0 to edge WIDTH+1.
- Back-to-back: start during the done cycle is accepted.
- start while busy=1 is ignored; no queueing.
- Divide by zero: no iteration fault. Result lo = all ones, hi = src_a (raw); div_zero=1. Same latency as any other divide.
- Signed overflow: most-negative / -1 gives lo = most-negative, hi = 0, div_zero=0.
- MTHI/MTLO:
  - Take effect on the next edge in IDLE.
  - Ignored while busy=1 (the pipeline must stall).
  - If hi_we/lo_we coincides with an accepted start, the write lands first; the start's operands are unaffected.
- hi/lo hold their values during CALC; the old values stay readable until the FIX edge.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a combinational WIDTH x WIDTH multiplier.
  - The accepted-start edge goes straight to FIX with the product registered, so done is high after edge 1.
  - Divides are unchanged.
- Not defined: all operations are iterative as above.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum, divide-by-zero LO constant.
- One sub-module, muldiv_abs: combinational conditional negate/abs, parametrised width. Instantiated for operand magnitude and for the FIX-stage sign correction.

Test Plan (WIDTH=32):
- MULT src_a=0xFFFFFFFE, src_b=3 -> done after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high edges 0-32.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1. The next accepted start clears div_zero.
- Second start mid-operation -> ignored, result is the first op's. lo_we while busy -> no change. Reset at edge 10 -> hi=lo=0, busy=0, no done pulse.
- With MULDIV_FAST_MUL_EN: MULT 6x7 -> done after edge 1, lo=42, hi=0. DIVU 7/2 still completes at edge 33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - op encodings for MULT/MULTU/DIV/DIVU
//   - the control state enum
//   - the LO value produced by a divide by zero
//   - small decode helpers for the op field
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // All-ones quotient reported for a zero divisor. Stored wide so that any
    // WIDTH up to 64 can take its low slice.
    localparam logic [63:0] DIV0_LO = '1;

    function automatic logic isDivide(input logic [1:0] opCode);
        return (opCode == OP_DIV) || (opCode == OP_DIVU);
    endfunction

    function automatic logic isSigned(input logic [1:0] opCode);
        return (opCode == OP_MULT) || (opCode == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// -----------------------------------------------------------------------------
// muldiv_abs
// Combinational conditional two's-complement negate. Used both to take the
// magnitude of a signed operand and to restore the sign of a result.
//   data_i  in  WIDTH  value
//   neg_i   in  1      1 = output -data_i, 0 = pass through
//   data_o  out WIDTH  result
// -----------------------------------------------------------------------------
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;

endmodule

// File: rtl/exec_muldiv.sv
// -----------------------------------------------------------------------------
// exec_muldiv
// Multi-cycle multiply/divide unit sitting beside the execute-stage ALU.
// Runs MULT/MULTU/DIV/DIVU into HI/LO one bit per cycle and accepts
// MTHI/MTLO writes while idle. The pipeline stalls MFHI/MFLO on busy.
//
// Ports:
//   clock     in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset
//   start     in  1      begin an operation (only looked at while idle)
//   op        in  2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     in  WIDTH  multiplicand / dividend
//   src_b     in  WIDTH  multiplier / divisor
//   hi_we     in  1      MTHI write enable
//   lo_we     in  1      MTLO write enable
//   wdata     in  WIDTH  MTHI/MTLO data
//   busy      out 1      operation in flight
//   done      out 1      one-cycle pulse when HI/LO are updated
//   div_zero  out 1      last division had a zero divisor (sticky to next start)
//   hi, lo    out WIDTH  architectural HI/LO
//
// Build option: define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a
// single-cycle combinational multiplier; divides stay iterative.
// WIDTH must be even, >= 4 and <= 64.
// -----------------------------------------------------------------------------
module exec_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t               state_q;
    logic [1:0]           op_q;
    logic                 signA_q;
    logic                 signB_q;
    logic                 zeroDiv_q;
    logic [CNT_W-1:0]     count_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 divZero_q;

    logic                 negA;
    logic                 negB;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [CNT_W-1:0]     count_d;
    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulStep_d;
    logic [WIDTH:0]       divTrial;
    logic [WIDTH:0]       divDiff;
    logic [2*WIDTH-1:0]   divStep_d;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quoFix;
    logic [WIDTH-1:0]     remFix;

    // Operand magnitudes: signed ops strip the sign, unsigned ops pass through.
    assign negA = isSigned(op) & src_a[WIDTH-1];
    assign negB = isSigned(op) & src_b[WIDTH-1];

    muldiv_abs #(.WIDTH(WIDTH)) uAbsA (.data_i(src_a), .neg_i(negA), .data_o(magA));
    muldiv_abs #(.WIDTH(WIDTH)) uAbsB (.data_i(src_b), .neg_i(negB), .data_o(magB));

    // Sign restoration at the end: product and quotient take the XOR of the
    // operand signs, the remainder follows the dividend. For unsigned ops the
    // latched signs are zero, so these are pass-through.
    muldiv_abs #(.WIDTH(2*WIDTH)) uFixProd (
        .data_i(acc_q), .neg_i(signA_q ^ signB_q), .data_o(prodFix));
    muldiv_abs #(.WIDTH(WIDTH)) uFixQuo (
        .data_i(acc_q[WIDTH-1:0]), .neg_i(signA_q ^ signB_q), .data_o(quoFix));
    muldiv_abs #(.WIDTH(WIDTH)) uFixRem (
        .data_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(signA_q), .data_o(remFix));

    // One iteration of each algorithm. The accumulator is shared:
    //   multiply: {partial product high half, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits shifting into quotient}
    // The divide trial value is WIDTH+1 bits wide because the shifted
    // remainder can exceed WIDTH bits before the subtraction.
    always_comb begin
        count_d   = count_q - CNT_W'(1);
        mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mulStep_d = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};
        divTrial  = acc_q[2*WIDTH-1:WIDTH-1];
        divDiff   = divTrial - {1'b0, opnd_q};
        divStep_d = divDiff[WIDTH] ? {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;
    assign fastProd = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
`endif

    // Control FSM and all architectural state. MTHI/MTLO are only honoured in
    // IDLE; when one coincides with an accepted start the write lands on the
    // same edge while the operands come straight from src_a/src_b.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            zeroDiv_q <= 1'b0;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        op_q      <= op;
                        signA_q   <= negA;
                        signB_q   <= negB;
                        zeroDiv_q <= isDivide(op) && (src_b == '0);
                        divZero_q <= 1'b0;
                        busy_q    <= 1'b1;
                        count_q   <= CNT_W'(WIDTH);
                        state_q   <= ST_CALC;
                        if (isDivide(op)) begin
                            acc_q  <= {{WIDTH{1'b0}}, magA};
                            opnd_q <= magB;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, magB};
                            opnd_q <= magA;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (!isDivide(op)) begin
                            acc_q   <= fastProd;
                            state_q <= ST_FIX;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    acc_q   <= isDivide(op_q) ? divStep_d : mulStep_d;
                    count_q <= count_d;
                    if (count_d == '0) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    // A zero divisor leaves quotient magnitude all ones and the
                    // remainder equal to the dividend, so only LO is forced.
                    if (isDivide(op_q)) begin
                        lo_q      <= zeroDiv_q ? DIV0_LO[WIDTH-1:0] : quoFix;
                        hi_q      <= remFix;
                        divZero_q <= zeroDiv_q;
                    end else begin
                        hi_q <= prodFix[2*WIDTH-1:WIDTH];
                        lo_q <= prodFix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divZero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
